ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  Multi-cycle RV32M/RV64M multiply/divide unit. It sits beside the combinational ALU in the execute stage.
//  - Takes MUL*/DIV*/REM* ops issued by id.
//  - Stalls the pipeline through ctrl while busy.
//  - Returns a registered result with rd/write-enable to mem/wb.
//  - Generalises execute to XLEN and configurable multiply latency.
// PARAMETERS
//  XLEN        32  datapath width (32 or 64)
//  MUL_STAGES  2   multiply pipeline depth, 1..4
// PORTS
//  clk             in   1     clock
//  rst             in   1     synchronous reset, active-high
//  req_valid_i     in   1     M-extension op present in execute
//  req_ready_o     out  1     1 only in IDLE
//  op_i            in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  rs1_i, rs2_i    in   XLEN  operands
//  reg_w_addr_i    in   5     destination register
//  flush_i         in   1     jump/flush from ctrl
//  stall_o         out  1     freeze upstream stages
//  res_valid_o     out  1     result valid, one cycle
//  reg_w_ena_o     out  1     equals res_valid_o
//  reg_w_addr_o    out  5     captured rd
//  reg_w_data_o    out  XLEN  result
// BEHAVIOUR
//  - Reset: state IDLE. reg_w_data_o, reg_w_addr_o, res_valid_o and reg_w_ena_o are 0. Divide cache is invalid.
//  - Reset mid-operation aborts the op with no result.
//  - FSM states: IDLE, MUL, DIV, DONE.
//  - Accept: req_valid_i & req_ready_o & ~flush_i at edge N. Operands, op and rd are latched.
//  - Multiply:
//    - Full 2*XLEN product. Operands are extended to XLEN+1 bits: signed for MULH, rs1-only for MULHSU.
//    - MUL returns the low half; the others return the high half.
//    - res_valid_o is high in cycle N+MUL_STAGES.
//  - Divide: radix-2 restoring divide on magnitudes, XLEN iterations, then one sign-fix cycle.
//    res_valid_o is high in cycle N+XLEN+1.
//  - Divide special cases finish in one cycle, res_valid_o high in cycle N+1:
//    - Divide by 0: quotient all-ones; remainder = rs1.
//    - Signed MIN/-1: quotient = MIN; remainder = 0.
//  - DONE lasts exactly one cycle, then the FSM returns to IDLE. There is no result back-pressure.
//  - stall_o = (req_valid_i & IDLE & ~flush_i) | MUL | DIV. It is low in DONE so the pipeline advances with the result.
//  - flush_i in MUL/DIV: go to IDLE next cycle; no result.
//  - flush_i in DONE: res_valid_o is forced 0 that cycle (res_valid_o = DONE & ~flush_i).
//  - flush_i together with req_valid_i in IDLE: the request is not accepted.
//  - reg_w_data_o holds its last value outside DONE.
// CONFIGURATION
//  MDU_DIV_CACHE_EN defined:
//    - Each completed DIV/DIVU/REM/REMU stores {signedness, rs1, rs2, quotient, remainder}.
//    - A later divide op with the same signedness and operands hits the cache and gives its result in cycle N+1.
//    - rst invalidates the cache. flush_i does not touch it.
//  MDU_DIV_CACHE_EN undefined: no cache storage; every divide takes the full latency.
// STRUCTURE
//  Package mdu_pkg holds:
//    - mdu_op_e (funct3 encodings)
//    - mdu_state_e
//    - the MUL_STAGES range check
//  Sub-module mdu_div_core holds the iterative divider and its counter:
//    - Inputs start, abort, magnitudes.
//    - Outputs quotient, remainder, done.
//  The ex_mdu top handles sign fix, special cases, cache and FSM. The multiply pipe stays inline.
// TESTING  (XLEN=32, MUL_STAGES=2)
//  1. MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB, res_valid at N+2; stall_o high N..N+1, low at N+2.
//  2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA at N+33. REM on the same operands -> 0xFFFFFFFE.
//  4. DIVU 5/0 -> 0xFFFFFFFF at N+1. REM 0x80000000/0xFFFFFFFF -> 0 at N+1.
//  5. flush_i at N+10 of a DIV: no res_valid, ready at N+11, next MUL accepted and correct. Same check for rst at N+10.
//  6. DIV 100/7 then REM 100/7 -> 14 at N+33, then 2 at N+1 with MDU_DIV_CACHE_EN, or at N+33 without it.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and parameter checks for the ex_mdu multiply/divide unit.
package mdu_pkg;

    // funct3 encodings of the RV32M/RV64M operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    // Control FSM states of the unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam int MUL_STAGES_MIN = 1;
    localparam int MUL_STAGES_MAX = 4;

    // True when the requested multiply pipeline depth is supported
    function automatic bit mul_stages_ok(input int stages);
        return (stages >= MUL_STAGES_MIN) && (stages <= MUL_STAGES_MAX);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; done pulses for one cycle when the last bit is in.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   count;
    logic            busy;
    logic [XLEN-1:0] dsr;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {remainder, quotient[XLEN-1]};
        diff    = shifted - {1'b0, dsr};
    end

    // Load operands on start, then retire one quotient bit per cycle
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy      <= 1'b1;
                count     <= CW'(XLEN);
                quotient  <= dividend;
                remainder <= '0;
                dsr       <= divisor;
            end else if (busy) begin
                if (!diff[XLEN]) begin
                    remainder <= diff[XLEN-1:0];
                    quotient  <= {quotient[XLEN-2:0], 1'b1};
                end else begin
                    remainder <= shifted[XLEN-1:0];
                    quotient  <= {quotient[XLEN-2:0], 1'b0};
                end
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle MUL*/DIV*/REM* with pipeline stall.
// Optional divide result cache enabled by defining MDU_DIV_CACHE_EN.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      reg_w_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            res_valid_o,
    output logic            reg_w_ena_o,
    output logic [4:0]      reg_w_addr_o,
    output logic [XLEN-1:0] reg_w_data_o
);

    if (!mul_stages_ok(MUL_STAGES)) begin : g_bad_mul_stages
        $error("ex_mdu: MUL_STAGES must be within 1..4");
    end

    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [1:0]      MUL_LAST = 2'(MUL_STAGES - 1);

    mdu_state_e      state;
    mdu_op_e         op_in;
    mdu_op_e         op_q;
    logic            accept;
    logic [1:0]      mul_cnt;

    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [2*XLEN-1:0] mul_pipe [MUL_STAGES];
    logic [XLEN-1:0]   mul_result;

    logic            div_signed_in;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            quick_in;
    logic [XLEN-1:0] quick_q_in;
    logic [XLEN-1:0] quick_r_in;
    logic            quick;
    logic [XLEN-1:0] quick_q_val;
    logic [XLEN-1:0] quick_r_val;
    logic            neg_q;
    logic            neg_r;
    logic            core_start;
    logic            core_done;
    logic [XLEN-1:0] core_q;
    logic [XLEN-1:0] core_r;
    logic [XLEN-1:0] fin_q;
    logic [XLEN-1:0] fin_r;
    logic            is_rem_q;

    logic            cache_hit;
    logic [XLEN-1:0] cache_q;
    logic [XLEN-1:0] cache_r;

    assign op_in       = mdu_op_e'(op_i);
    assign accept      = req_valid_i & (state == ST_IDLE) & ~flush_i;
    assign req_ready_o = (state == ST_IDLE);
    assign stall_o     = (req_valid_i & (state == ST_IDLE) & ~flush_i)
                       | (state == ST_MUL) | (state == ST_DIV);
    assign res_valid_o = (state == ST_DONE) & ~flush_i;
    assign reg_w_ena_o = res_valid_o;

    // Operand extension and full-width product of the incoming request
    always_comb begin
        mul_a    = {{XLEN{((op_in == OP_MULH) || (op_in == OP_MULHSU)) & rs1_i[XLEN-1]}}, rs1_i};
        mul_b    = {{XLEN{(op_in == OP_MULH) & rs2_i[XLEN-1]}}, rs2_i};
        mul_prod = mul_a * mul_b;
    end

    // Free-running product pipe; the FSM picks the last stage at the right time
    always_ff @(posedge clk) begin
        mul_pipe[0] <= mul_prod;
        for (int i = 1; i < MUL_STAGES; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    assign mul_result = (op_q == OP_MUL) ? mul_pipe[MUL_STAGES-1][XLEN-1:0]
                                         : mul_pipe[MUL_STAGES-1][2*XLEN-1:XLEN];

    // Divide operand magnitudes and the one-cycle special cases
    always_comb begin
        div_signed_in = (op_in == OP_DIV) || (op_in == OP_REM);
        rs1_neg       = div_signed_in & rs1_i[XLEN-1];
        rs2_neg       = div_signed_in & rs2_i[XLEN-1];
        mag_a         = rs1_neg ? -rs1_i : rs1_i;
        mag_b         = rs2_neg ? -rs2_i : rs2_i;
        quick_in      = 1'b0;
        quick_q_in    = '0;
        quick_r_in    = '0;
        if (rs2_i == '0) begin
            quick_in   = 1'b1;
            quick_q_in = '1;
            quick_r_in = rs1_i;
        end else if (div_signed_in && (rs1_i == XMIN) && (rs2_i == '1)) begin
            quick_in   = 1'b1;
            quick_q_in = XMIN;
            quick_r_in = '0;
        end else if (cache_hit) begin
            quick_in   = 1'b1;
            quick_q_in = cache_q;
            quick_r_in = cache_r;
        end
    end

    assign core_start = accept & op_i[2] & ~quick_in;

    mdu_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .abort     (flush_i),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (core_q),
        .remainder (core_r),
        .done      (core_done)
    );

    // Sign fix of the divider output, or the latched quick result
    always_comb begin
        is_rem_q = (op_q == OP_REM) || (op_q == OP_REMU);
        fin_q    = neg_q ? -core_q : core_q;
        fin_r    = neg_r ? -core_r : core_r;
        if (quick) begin
            fin_q = quick_q_val;
            fin_r = quick_r_val;
        end
    end

`ifdef MDU_DIV_CACHE_EN
    logic            cache_valid;
    logic            cache_signed;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;

    assign cache_hit = cache_valid & (cache_signed == div_signed_in)
                     & (cache_a == rs1_i) & (cache_b == rs2_i);

    // Remember the operands and result of the most recent completed divide
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_q      <= '0;
            cache_r      <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
        end else begin
            if (accept) begin
                rs1_q <= rs1_i;
                rs2_q <= rs2_i;
            end
            if ((state == ST_DIV) && !flush_i && (quick || core_done)) begin
                cache_valid  <= 1'b1;
                cache_signed <= (op_q == OP_DIV) || (op_q == OP_REM);
                cache_a      <= rs1_q;
                cache_b      <= rs2_q;
                cache_q      <= fin_q;
                cache_r      <= fin_r;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_q   = '0;
    assign cache_r   = '0;
`endif

    // Control FSM: accept, wait for multiply/divide, present the result for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= OP_MUL;
            mul_cnt      <= '0;
            quick        <= 1'b0;
            quick_q_val  <= '0;
            quick_r_val  <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            reg_w_addr_o <= '0;
            reg_w_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q         <= op_in;
                        reg_w_addr_o <= reg_w_addr_i;
                        mul_cnt      <= MUL_LAST;
                        quick        <= quick_in;
                        quick_q_val  <= quick_q_in;
                        quick_r_val  <= quick_r_in;
                        neg_q        <= rs1_neg ^ rs2_neg;
                        neg_r        <= rs1_neg;
                        state        <= op_i[2] ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (flush_i) begin
                        state <= ST_IDLE;
                    end else if (mul_cnt == 2'd0) begin
                        reg_w_data_o <= mul_result;
                        state        <= ST_DONE;
                    end else begin
                        mul_cnt <= mul_cnt - 2'd1;
                    end
                end
                ST_DIV: begin
                    if (flush_i) begin
                        state <= ST_IDLE;
                    end else if (quick || core_done) begin
                        reg_w_data_o <= is_rem_q ? fin_r : fin_q;
                        state        <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu (XLEN=32, MUL_STAGES=2), directed plus random ops.
// Honours MDU_DIV_CACHE_EN when computing expected divide latency.
module tb_ex_mdu;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      reg_w_addr_i;
    logic            flush_i;
    logic            stall_o;
    logic            res_valid_o;
    logic            reg_w_ena_o;
    logic [4:0]      reg_w_addr_o;
    logic [XLEN-1:0] reg_w_data_o;

    int vectors     = 0;
    int miscompares = 0;

    bit          cache_valid  = 1'b0;
    bit          cache_signed = 1'b0;
    logic [31:0] cache_a      = '0;
    logic [31:0] cache_b      = '0;

    ex_mdu #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_i         (op_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .reg_w_addr_i (reg_w_addr_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .res_valid_o  (res_valid_o),
        .reg_w_ena_o  (reg_w_ena_o),
        .reg_w_addr_o (reg_w_addr_o),
        .reg_w_data_o (reg_w_data_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Architectural result of an M-extension op from plain arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected cycles from accept edge to the result cycle
    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_STAGES;
        if (b == 0) return 1;
        if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef MDU_DIV_CACHE_EN
        if (cache_valid && (cache_signed == !op[0]) && (cache_a == a) && (cache_b == b)) return 1;
`endif
        return XLEN + 1;
    endfunction

    // One comparison: count it, and report any difference
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one op, then check stall, latency, result and rd
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int          lat;
        int          k;
        logic [31:0] expv;
        expv = ref_result(op, a, b);
        lat  = exp_latency(op, a, b);
        k    = 0;
        @(negedge clk);
        while (!req_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("ready_before_req", 64'(req_ready_o), 64'd1);
        op_i         = op;
        rs1_i        = a;
        rs2_i        = b;
        reg_w_addr_i = rd;
        req_valid_i  = 1'b1;
        #1;
        checkOutput("stall_on_request", 64'(stall_o), 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        checkOutput("stall_busy", 64'(stall_o), 64'd1);
        k = 0;
        while (!res_valid_o && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput($sformatf("latency op%0d", op), 64'(k), 64'(lat));
        checkOutput($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(reg_w_data_o), 64'(expv));
        checkOutput("reg_w_ena", 64'(reg_w_ena_o), 64'd1);
        checkOutput("reg_w_addr", 64'(reg_w_addr_o), 64'(rd));
        checkOutput("stall_in_done", 64'(stall_o), 64'd0);
        if (op[2] && res_valid_o) begin
            cache_valid  = 1'b1;
            cache_signed = !op[0];
            cache_a      = a;
            cache_b      = b;
        end
    endtask

    // Start a request and leave the bench in cycle N (just after the accept edge)
    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        op_i        = op;
        rs1_i       = a;
        rs2_i       = b;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    // Global time bound so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed steps followed by random ops
    initial begin
        int          hits;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] last_a;
        logic [31:0] last_b;
        int          sel;

        rst          = 1'b1;
        req_valid_i  = 1'b0;
        flush_i      = 1'b0;
        op_i         = '0;
        rs1_i        = '0;
        rs2_i        = '0;
        reg_w_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 64'(req_ready_o), 64'd1);
        checkOutput("reset_valid", 64'(res_valid_o), 64'd0);
        checkOutput("reset_ena", 64'(reg_w_ena_o), 64'd0);
        checkOutput("reset_data", 64'(reg_w_data_o), 64'd0);
        checkOutput("reset_addr", 64'(reg_w_addr_o), 64'd0);
        checkOutput("reset_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
        applyStimulus(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5);
        applyStimulus(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6);
        applyStimulus(3'd5, 32'd5, 32'd0, 5'd7);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);

        // request together with flush in IDLE must not be taken
        @(negedge clk);
        op_i        = 3'd0;
        rs1_i       = 32'd3;
        rs2_i       = 32'd4;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        checkOutput("flush_req_stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("flush_req_not_taken", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b0;
        flush_i     = 1'b0;

        // flush in DONE suppresses the result
        startOp(3'd0, 32'd9, 32'd9);
        repeat (MUL_STAGES) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        checkOutput("flush_done_valid", 64'(res_valid_o), 64'd0);
        checkOutput("flush_done_ena", 64'(reg_w_ena_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("flush_done_ready", 64'(req_ready_o), 64'd1);

        // flush mid-divide aborts with no result
        startOp(3'd4, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("flush_div_ready", 64'(req_ready_o), 64'd1);
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid_o) hits++;
        end
        checkOutput("flush_div_no_result", 64'(hits), 64'd0);
        applyStimulus(3'd0, 32'd123, 32'd456, 5'd10);

        // reset mid-divide aborts with no result and clears the cache
        startOp(3'd4, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        cache_valid = 1'b0;
        checkOutput("rst_div_ready", 64'(req_ready_o), 64'd1);
        checkOutput("rst_div_data", 64'(reg_w_data_o), 64'd0);
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid_o) hits++;
        end
        checkOutput("rst_div_no_result", 64'(hits), 64'd0);
        applyStimulus(3'd0, 32'hDEAD_BEEF, 32'd3, 5'd11);

        applyStimulus(3'd4, 32'd100, 32'd7, 5'd12);
        applyStimulus(3'd6, 32'd100, 32'd7, 5'd13);

        last_a = 32'd100;
        last_b = 32'd7;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2 || sel == 3) begin
                ra = last_a;
                rb = last_b;
            end
            applyStimulus(rop, ra, rb, 5'($urandom_range(0, 31)));
            last_a = ra;
            last_b = rb;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
